// File: rtl/bp_pkg.sv
// Shared types and constants for the gshare predictor table controller.
package bp_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bp_state_e;

    // pattern is stored 32 bits wide; only the low GBIT bits are meaningful
    typedef struct packed {
        logic        is_jump;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic [31:0] pattern;
    } bp_upd_t;

    localparam logic [1:0]  PHT_INIT    = 2'b01;
    localparam logic [31:0] TAG_INVALID = 32'hFFFF_FFFF;

    function automatic logic [1:0] sat_cnt2(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == 2'b11) ? cnt : cnt + 2'b01;
        end
        return (cnt == 2'b00) ? cnt : cnt - 2'b01;
    endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Update FIFO between Execute and the table read-modify-write pipeline.
module bp_upd_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  logic    i_flush,
    input  logic    i_push,
    input  bp_upd_t i_data,
    input  logic    i_pop,
    output bp_upd_t o_data,
    output logic    o_full,
    output logic    o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    bp_upd_t       mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign o_full  = (count == CW'(DEPTH));
    assign o_empty = (count == '0);
    assign do_push = i_push & !o_full;
    assign do_pop  = i_pop & !o_empty;
    assign o_data  = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= i_data;
    end

endmodule

// File: rtl/bp_table_ctrl.sv
// gshare table sequencer: init sweep, update FIFO, PHT/BTB read-modify-write,
// misprediction redirect and global history.
module bp_table_ctrl
    import bp_pkg::*;
#(
    parameter int GBIT  = 10,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_upd_valid,
    output logic             o_upd_ready,
    input  logic             i_upd_is_jump,
    input  logic [31:0]      i_upd_pc,
    input  logic             i_upd_taken,
    input  logic [31:0]      i_upd_target,
    input  logic [GBIT-1:0]  i_upd_pattern,
    input  logic             i_upd_pred_taken,
    input  logic [31:0]      i_upd_pred_target,
    output logic             o_redirect_valid,
    output logic [31:0]      o_redirect_pc,
    output logic [GBIT-1:0]  o_ghr,
    output logic             o_pred_en,
    output logic [GBIT-1:0]  o_tbl_rd_idx,
    input  logic [1:0]       i_tbl_rd_pht,
    output logic             o_pht_we,
    output logic [GBIT-1:0]  o_pht_idx,
    output logic [1:0]       o_pht_data,
    output logic             o_btb_we,
    output logic [GBIT-1:0]  o_btb_idx,
    output logic [31-GBIT:0] o_btb_tag,
    output logic [31:0]      o_btb_target
);
    bp_state_e       state;
    logic [GBIT-1:0] sweep_idx;
    logic [GBIT-1:0] sweep_wr_idx;
    logic            sweep_we;
    bp_upd_t         enq_data;
    bp_upd_t         head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            accept;
    logic            pop;
    logic            mispredict;
    logic [31:0]     redir_pc;
    logic [GBIT-1:0] rd_idx;
    logic [1:0]      rd_cnt;
    logic            w_valid;
    logic            w_is_jump;
    logic            w_taken;
    logic [31:0]     w_pc;
    logic [31:0]     w_target;
    logic [GBIT-1:0] w_idx;
    logic [1:0]      w_cnt;
    logic [1:0]      w_new_cnt;
    logic            w_pht_we;
    logic            w_btb_we;
    logic            unused_pattern_bits;

    // Handshake: an update transfers on a cycle where i_upd_valid && o_upd_ready;
    // ready depends only on the run state, FIFO count and flush, never on valid.
    assign o_upd_ready = o_pred_en & !fifo_full & !i_flush;
    assign accept      = i_upd_valid & o_upd_ready;
    assign pop         = !fifo_empty & !i_flush;

    always_comb begin
        enq_data                    = '0;
        enq_data.is_jump            = i_upd_is_jump;
        enq_data.pc                 = i_upd_pc;
        enq_data.taken              = i_upd_taken;
        enq_data.target             = i_upd_target;
        enq_data.pattern[GBIT-1:0]  = i_upd_pattern;
    end

    always_comb begin
        mispredict = 1'b0;
        redir_pc   = i_upd_target;
        if (i_upd_is_jump) begin
            mispredict = !(i_upd_pred_taken && (i_upd_pred_target == i_upd_target));
        end else begin
            mispredict = (i_upd_pred_taken != i_upd_taken) ||
                         (i_upd_taken && i_upd_pred_taken && (i_upd_pred_target != i_upd_target));
            redir_pc   = i_upd_taken ? i_upd_target : i_upd_pc + 32'd4;
        end
    end

    bp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_flush),
        .i_push  (accept),
        .i_data  (enq_data),
        .i_pop   (pop),
        .o_data  (head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign rd_idx              = head.pc[GBIT-1:0] ^ head.pattern[GBIT-1:0];
    assign o_tbl_rd_idx        = rd_idx;
    assign unused_pattern_bits = ^head.pattern[31:GBIT];

    assign w_new_cnt = sat_cnt2(w_cnt, w_taken);
    assign w_pht_we  = w_valid & !w_is_jump & !i_flush;
    assign w_btb_we  = w_valid & w_taken & !i_flush;
    // the table only sees W's write at the next edge, so R takes it from W directly
    assign rd_cnt    = (w_valid && !w_is_jump && (w_idx == rd_idx)) ? w_new_cnt : i_tbl_rd_pht;

    assign o_pht_we     = sweep_we | w_pht_we;
    assign o_pht_idx    = sweep_we ? sweep_wr_idx : w_idx;
    assign o_pht_data   = sweep_we ? PHT_INIT : w_new_cnt;
    assign o_btb_we     = sweep_we | w_btb_we;
    assign o_btb_idx    = sweep_we ? sweep_wr_idx : w_pc[GBIT-1:0];
    assign o_btb_tag    = sweep_we ? TAG_INVALID[31-GBIT:0] : w_pc[31:GBIT];
    assign o_btb_target = sweep_we ? 32'd0 : w_target;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            state            <= INIT;
            sweep_idx        <= '0;
            sweep_wr_idx     <= '0;
            sweep_we         <= 1'b0;
            o_pred_en        <= 1'b0;
            o_ghr            <= '0;
            o_redirect_valid <= 1'b0;
            w_valid          <= 1'b0;
            if (!i_rst_n) o_redirect_pc <= '0;
        end else begin
            o_redirect_valid <= accept & mispredict;
            if (accept && mispredict) o_redirect_pc <= redir_pc;
            w_valid <= pop;
            if (w_pht_we) o_ghr <= {w_taken, o_ghr[GBIT-1:1]};
            case (state)
                INIT: begin
                    sweep_we     <= 1'b1;
                    sweep_wr_idx <= sweep_idx;
                    sweep_idx    <= sweep_idx + 1'b1;
                    o_pred_en    <= 1'b0;
                    if (sweep_idx == '1) state <= RUN;
                end
                RUN: begin
                    sweep_we  <= 1'b0;
                    o_pred_en <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (pop) begin
            w_is_jump <= head.is_jump;
            w_taken   <= head.taken;
            w_pc      <= head.pc;
            w_target  <= head.target;
            w_idx     <= rd_idx;
            w_cnt     <= rd_cnt;
        end
    end

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Randomized bench for bp_table_ctrl against a table-level reference model.
module tb_bp_table_ctrl;
    localparam int GBIT  = 4;
    localparam int DEPTH = 4;
    localparam int N     = 16;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_flush = 1'b0;
    logic             i_upd_valid = 1'b0;
    logic             o_upd_ready;
    logic             i_upd_is_jump = 1'b0;
    logic [31:0]      i_upd_pc = '0;
    logic             i_upd_taken = 1'b0;
    logic [31:0]      i_upd_target = '0;
    logic [GBIT-1:0]  i_upd_pattern = '0;
    logic             i_upd_pred_taken = 1'b0;
    logic [31:0]      i_upd_pred_target = '0;
    logic             o_redirect_valid;
    logic [31:0]      o_redirect_pc;
    logic [GBIT-1:0]  o_ghr;
    logic             o_pred_en;
    logic [GBIT-1:0]  o_tbl_rd_idx;
    logic [1:0]       i_tbl_rd_pht;
    logic             o_pht_we;
    logic [GBIT-1:0]  o_pht_idx;
    logic [1:0]       o_pht_data;
    logic             o_btb_we;
    logic [GBIT-1:0]  o_btb_idx;
    logic [31-GBIT:0] o_btb_tag;
    logic [31:0]      o_btb_target;

    bp_table_ctrl #(.GBIT(GBIT), .DEPTH(DEPTH)) dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_flush           (i_flush),
        .i_upd_valid       (i_upd_valid),
        .o_upd_ready       (o_upd_ready),
        .i_upd_is_jump     (i_upd_is_jump),
        .i_upd_pc          (i_upd_pc),
        .i_upd_taken       (i_upd_taken),
        .i_upd_target      (i_upd_target),
        .i_upd_pattern     (i_upd_pattern),
        .i_upd_pred_taken  (i_upd_pred_taken),
        .i_upd_pred_target (i_upd_pred_target),
        .o_redirect_valid  (o_redirect_valid),
        .o_redirect_pc     (o_redirect_pc),
        .o_ghr             (o_ghr),
        .o_pred_en         (o_pred_en),
        .o_tbl_rd_idx      (o_tbl_rd_idx),
        .i_tbl_rd_pht      (i_tbl_rd_pht),
        .o_pht_we          (o_pht_we),
        .o_pht_idx         (o_pht_idx),
        .o_pht_data        (o_pht_data),
        .o_btb_we          (o_btb_we),
        .o_btb_idx         (o_btb_idx),
        .o_btb_tag         (o_btb_tag),
        .o_btb_target      (o_btb_target)
    );

    // clock and the external PHT storage the controller reads and writes
    always #5 i_clk = ~i_clk;

    logic [1:0] pht_mem [N];
    always @(posedge i_clk) begin
        if (o_pht_we) pht_mem[o_pht_idx] <= o_pht_data;
    end
    assign i_tbl_rd_pht = pht_mem[o_tbl_rd_idx];

    // reference model and scoreboard
    int              pht_m [N];
    logic [GBIT-1:0] ghr_m;
    logic [5:0]      exp_pht_q [$];
    logic [63:0]     exp_btb_q [$];
    int              n_checks = 0;
    int              n_fail = 0;
    logic            mon_en = 1'b0;

    logic [31:0] r_pc, r_tg, r_ptg;
    logic        r_j, r_tk, r_pt;
    logic [3:0]  r_pat;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (mon_en) begin
            if (o_pht_we) begin
                if (exp_pht_q.size() == 0) check("pht_extra_we", o_pht_we, 1'b0);
                else check("pht_write", {o_pht_idx, o_pht_data}, exp_pht_q.pop_front());
            end
            if (o_btb_we) begin
                if (exp_btb_q.size() == 0) check("btb_extra_we", o_btb_we, 1'b0);
                else check("btb_write", {o_btb_idx, o_btb_tag, o_btb_target}, exp_btb_q.pop_front());
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < N; i++) pht_m[i] = 1;
        ghr_m = '0;
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_pht_q"}, exp_pht_q.size(), 0);
        check({tag, "_btb_q"}, exp_btb_q.size(), 0);
        exp_pht_q.delete();
        exp_btb_q.delete();
    endtask

    // drivers
    task automatic send(input logic is_jump, input logic [31:0] pc, input logic taken,
                        input logic [31:0] target, input logic [3:0] pattern,
                        input logic pred_taken, input logic [31:0] pred_target, input bit commit);
        logic        mis;
        logic [31:0] rpc;
        int          idx;
        int          c;
        i_upd_valid       = 1'b1;
        i_upd_is_jump     = is_jump;
        i_upd_pc          = pc;
        i_upd_taken       = taken;
        i_upd_target      = target;
        i_upd_pattern     = pattern;
        i_upd_pred_taken  = pred_taken;
        i_upd_pred_target = pred_target;
        if (is_jump) begin
            mis = !(pred_taken && pred_target == target);
            rpc = target;
        end else begin
            mis = (taken != pred_taken) || (taken && pred_target != target);
            rpc = taken ? target : pc + 32'd4;
        end
        @(negedge i_clk);
        check("upd_ready", o_upd_ready, 1'b1);
        @(posedge i_clk);
        #1;
        i_upd_valid = 1'b0;
        check("redirect_valid", o_redirect_valid, mis);
        if (mis) check("redirect_pc", o_redirect_pc, rpc);
        if (commit) begin
            if (!is_jump) begin
                idx = int'(pc[3:0] ^ pattern);
                c = pht_m[idx];
                c = taken ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
                pht_m[idx] = c;
                exp_pht_q.push_back({idx[3:0], c[1:0]});
                ghr_m = {taken, ghr_m[GBIT-1:1]};
            end
            if (taken) exp_btb_q.push_back({pc[3:0], pc[31:4], target});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk);
            #1;
            check("redirect_idle", o_redirect_valid, 1'b0);
        end
    endtask

    task automatic sweep_check();
        for (int k = 0; k < N; k++) begin
            @(posedge i_clk);
            #1;
            check("sweep_pht", {o_pht_we, o_pht_idx, o_pht_data}, {1'b1, k[3:0], 2'b01});
            check("sweep_btb", {o_btb_we, o_btb_idx, o_btb_tag, o_btb_target},
                  {1'b1, k[3:0], 28'hFFF_FFFF, 32'h0});
            check("sweep_gate", {o_pred_en, o_upd_ready}, 2'b00);
        end
        @(posedge i_clk);
        #1;
        i_upd_valid = 1'b0;
        check("sweep_done", {o_pred_en, o_upd_ready, o_pht_we, o_btb_we}, 4'b1100);
    endtask

    task automatic rand_send(input bit commit);
        r_j   = ($urandom_range(0, 3) == 0);
        r_pc  = $urandom;
        r_tk  = r_j ? 1'b1 : 1'($urandom_range(0, 1));
        r_tg  = $urandom;
        r_pt  = 1'($urandom_range(0, 1));
        r_ptg = ($urandom_range(0, 1) == 1) ? r_tg : $urandom;
        r_pat = 4'($urandom_range(0, 15));
        send(r_j, r_pc, r_tk, r_tg, r_pat, r_pt, r_ptg, commit);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge i_clk);
        #1;
        check("reset_state", {o_ghr, o_redirect_valid, o_redirect_pc, o_pred_en, o_upd_ready,
                              o_pht_we, o_btb_we}, '0);
        i_rst_n = 1'b1;
        sweep_check();
        mon_en = 1'b1;

        // repeated taken branch at one index: counter saturates through forwarding
        repeat (4) send(1'b0, 32'h40, 1'b1, 32'h80, 4'h0, 1'b1, 32'h80, 1);
        idle(3);
        check("ghr_after_taken", o_ghr, ghr_m);
        check_drained("taken");

        send(1'b0, 32'h100, 1'b1, 32'h200, 4'h0, 1'b0, 32'h0, 1);
        send(1'b0, 32'h100, 1'b0, 32'h200, 4'h0, 1'b1, 32'h200, 1);
        send(1'b1, 32'h20, 1'b1, 32'h300, 4'h0, 1'b0, 32'h0, 1);
        idle(3);
        check("ghr_after_jump", o_ghr, ghr_m);
        check_drained("redirect");

        // back-to-back random updates, the first five with no gaps
        for (int n = 0; n < 40; n++) begin
            rand_send(1);
            if (n >= 5 && $urandom_range(0, 4) == 0) idle(1);
        end
        idle(3);
        check("ghr_random", o_ghr, ghr_m);
        check_drained("random");

        // flush with updates still in the pipeline
        send(1'b0, 32'h500, 1'b1, 32'h600, 4'h3, 1'b1, 32'h600, 1);
        send(1'b0, 32'h514, 1'b1, 32'h604, 4'h5, 1'b1, 32'h604, 0);
        send(1'b0, 32'h528, 1'b1, 32'h608, 4'h7, 1'b0, 32'h0, 0);
        i_flush           = 1'b1;
        i_upd_valid       = 1'b1;
        i_upd_is_jump     = 1'b0;
        i_upd_pc          = 32'h700;
        i_upd_taken       = 1'b1;
        i_upd_target      = 32'h900;
        i_upd_pattern     = 4'h2;
        i_upd_pred_taken  = 1'b0;
        @(negedge i_clk);
        check("flush_ready", o_upd_ready, 1'b0);
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        mon_en  = 1'b0;
        check("flush_state", {o_ghr, o_pred_en, o_redirect_valid}, '0);
        model_reset();
        check_drained("flush");
        sweep_check();
        mon_en = 1'b1;
        for (int n = 0; n < 8; n++) rand_send(1);
        idle(3);
        check("ghr_post_flush", o_ghr, ghr_m);
        check_drained("post_flush");

        // reset in the middle of an update stream
        rand_send(1);
        rand_send(0);
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        mon_en = 1'b0;
        @(posedge i_clk);
        #1;
        check("midrun_reset", {o_ghr, o_redirect_valid, o_redirect_pc, o_pred_en, o_upd_ready,
                               o_pht_we, o_btb_we}, '0);
        i_rst_n = 1'b1;
        model_reset();
        check_drained("reset");
        sweep_check();
        mon_en = 1'b1;
        for (int n = 0; n < 8; n++) rand_send(1);
        idle(3);
        check("ghr_final", o_ghr, ghr_m);
        check_drained("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
